tft_ctrlmod: RTL and testbench

Low-level 8080-style parallel write engine for the 16-bit TFT panel. It sits directly below the TFT function layer (init, clear-screen and draw sequencers). It turns one-hot call requests into three primitives: a hardware reset pulse, a command write (RS=0) or a data write (RS=1). Each primitive is finished with a single-cycle oDone pulse, so upstream sequencers can chain writes with the codebase's standard call/done handshake.

---
 rtl/tft_pkg.sv | 29 ++
 rtl/tft_ctrlmod_if.sv | 23 ++
 rtl/tft_dly.sv | 28 ++
 rtl/tft_ctrlmod.sv | 125 ++++++++++++
 tb/tb_tft_ctrlmod.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT 8080-style write engine.
// State encoding, call bit indices and the counter-preload helper live here.
package tft_pkg;

  localparam int CNT_W    = 24;
  localparam int CALL_RST = 0;
  localparam int CALL_CMD = 1;
  localparam int CALL_DAT = 2;

  localparam logic RS_CMD = 1'b0;
  localparam logic RS_DAT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LO,
    S_RST_WAIT,
    S_SETUP,
    S_WR_LO,
    S_WR_HI,
    S_DONE,
    S_GAP
  } state_t;

  // A state lasting p cycles is entered with the counter at p-1.
  function automatic logic [CNT_W-1:0] cnt_init(input int unsigned p);
    return CNT_W'(p - 1);
  endfunction

endpackage

// File: rtl/tft_ctrlmod_if.sv
// Call/done handshake plus the TFT parallel-bus pins of the write engine.
// The master is the upstream sequencer; the slave is tft_ctrlmod.
interface tft_ctrlmod_if;
  logic [2:0]  iCall;
  logic [15:0] iData;
  logic        oDone;
  logic        TFT_RST;
  logic        TFT_RS;
  logic        TFT_CS_N;
  logic        TFT_WR_N;
  logic        TFT_RD_N;
  logic [15:0] TFT_DB;

  modport master (
    output iCall, iData,
    input  oDone, TFT_RST, TFT_RS, TFT_CS_N, TFT_WR_N, TFT_RD_N, TFT_DB
  );

  modport slave (
    input  iCall, iData,
    output oDone, TFT_RST, TFT_RS, TFT_CS_N, TFT_WR_N, TFT_RD_N, TFT_DB
  );
endinterface

// File: rtl/tft_dly.sv
// Loadable down-counter shared by every timed state of the write engine.
// o_expire is high while the count sits at zero.
module tft_dly
  import tft_pkg::*;
(
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/tft_ctrlmod.sv
// 8080-style TFT write engine: hard reset pulse, command write and data write,
// each closed by a one-cycle oDone. All pins are driven straight from flops.
module tft_ctrlmod
  import tft_pkg::*;
#(
  parameter int unsigned T_RST_LOW  = 50000,
  parameter int unsigned T_RST_WAIT = 6000000,
  parameter int unsigned T_SETUP    = 1,
  parameter int unsigned T_WRL      = 2,
  parameter int unsigned T_WRH      = 2
) (
  input  logic          CLOCK,
  input  logic          RESET,
  tft_ctrlmod_if.slave  bus
);

  state_t           r_state, w_state_nxt;
  logic             w_load, w_expire;
  logic [CNT_W-1:0] w_value;

  logic        r_rst, r_rs, r_cs_n, r_wr_n, r_done;
  logic [15:0] r_db;
  logic        w_rst_nxt, w_rs_nxt, w_cs_n_nxt, w_wr_n_nxt, w_done_nxt;
  logic [15:0] w_db_nxt;

  tft_dly u_dly (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .i_load   (w_load),
    .i_value  (w_value),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_rst   <= 1'b1;
      r_rs    <= 1'b1;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_done  <= 1'b0;
      r_db    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rst   <= w_rst_nxt;
      r_rs    <= w_rs_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_wr_n  <= w_wr_n_nxt;
      r_done  <= w_done_nxt;
      r_db    <= w_db_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_value     = '0;
    w_rst_nxt   = r_rst;
    w_rs_nxt    = r_rs;
    w_cs_n_nxt  = r_cs_n;
    w_wr_n_nxt  = r_wr_n;
    w_db_nxt    = r_db;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Hard reset outranks both writes; command outranks data.
        if (bus.iCall[CALL_RST]) begin
          w_rst_nxt   = 1'b0;
          w_load      = 1'b1;
          w_value     = cnt_init(T_RST_LOW);
          w_state_nxt = S_RST_LO;
        end else if (bus.iCall[CALL_CMD] || bus.iCall[CALL_DAT]) begin
          w_db_nxt    = bus.iData;
          w_rs_nxt    = bus.iCall[CALL_CMD] ? RS_CMD : RS_DAT;
          w_cs_n_nxt  = 1'b0;
          w_load      = 1'b1;
          w_value     = cnt_init(T_SETUP);
          w_state_nxt = S_SETUP;
        end
      end
      S_RST_LO: if (w_expire) begin
        w_rst_nxt   = 1'b1;
        w_load      = 1'b1;
        w_value     = cnt_init(T_RST_WAIT);
        w_state_nxt = S_RST_WAIT;
      end
      S_RST_WAIT: if (w_expire) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_SETUP: if (w_expire) begin
        w_wr_n_nxt  = 1'b0;
        w_load      = 1'b1;
        w_value     = cnt_init(T_WRL);
        w_state_nxt = S_WR_LO;
      end
      S_WR_LO: if (w_expire) begin
        w_wr_n_nxt  = 1'b1;
        w_load      = 1'b1;
        w_value     = cnt_init(T_WRH);
        w_state_nxt = S_WR_HI;
      end
      S_WR_HI: if (w_expire) begin
        w_cs_n_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_GAP;
      // One dead cycle lets the caller drop its call bit before IDLE looks again.
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.oDone    = r_done;
  assign bus.TFT_RST  = r_rst;
  assign bus.TFT_RS   = r_rs;
  assign bus.TFT_CS_N = r_cs_n;
  assign bus.TFT_WR_N = r_wr_n;
  assign bus.TFT_RD_N = 1'b1;
  assign bus.TFT_DB   = r_db;

endmodule

// File: tb/tb_tft_ctrlmod.sv
// Self-checking bench for tft_ctrlmod: a monitor logs pin events by cycle and
// each request is compared against timings derived from the protocol rules.
module tb_tft_ctrlmod;
  import tft_pkg::*;

  localparam int T_RST_LOW  = 4;
  localparam int T_RST_WAIT = 6;
  localparam int T_SETUP    = 1;
  localparam int T_WRL      = 2;
  localparam int T_WRH      = 2;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;

  tft_ctrlmod_if bus ();

  tft_ctrlmod #(
    .T_RST_LOW  (T_RST_LOW),
    .T_RST_WAIT (T_RST_WAIT),
    .T_SETUP    (T_SETUP),
    .T_WRL      (T_WRL),
    .T_WRH      (T_WRH)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #10 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Event logs, one entry per completed pulse.
  int          done_q[$];
  int          cs_fall_q[$], cs_w_q[$];
  int          wr_fall_q[$], wr_w_q[$];
  logic [15:0] wr_dbf_q[$], wr_dbr_q[$];
  logic        wr_rs_q[$];
  int          rst_fall_q[$], rst_w_q[$];

  bit          in_cs, in_wr, in_rst;
  int          cs_start, wr_start, rst_start;
  logic [15:0] db_at_fall;
  logic        rs_at_fall;

  always @(posedge CLOCK) begin
    #1;
    if (!RESET) begin
      in_cs = 0; in_wr = 0; in_rst = 0;
    end else begin
      if (bus.oDone === 1'b1) done_q.push_back(cyc);
      if (!in_cs && bus.TFT_CS_N === 1'b0) begin
        in_cs = 1; cs_start = cyc;
      end else if (in_cs && bus.TFT_CS_N === 1'b1) begin
        in_cs = 0; cs_fall_q.push_back(cs_start); cs_w_q.push_back(cyc - cs_start);
      end
      if (!in_wr && bus.TFT_WR_N === 1'b0) begin
        in_wr = 1; wr_start = cyc; db_at_fall = bus.TFT_DB; rs_at_fall = bus.TFT_RS;
      end else if (in_wr && bus.TFT_WR_N === 1'b1) begin
        in_wr = 0;
        wr_fall_q.push_back(wr_start); wr_w_q.push_back(cyc - wr_start);
        wr_dbf_q.push_back(db_at_fall); wr_dbr_q.push_back(bus.TFT_DB);
        wr_rs_q.push_back(rs_at_fall);
      end
      if (!in_rst && bus.TFT_RST === 1'b0) begin
        in_rst = 1; rst_start = cyc;
      end else if (in_rst && bus.TFT_RST === 1'b1) begin
        in_rst = 0; rst_fall_q.push_back(rst_start); rst_w_q.push_back(cyc - rst_start);
      end
    end
  end

  // Reference model state.
  logic [15:0] model_db    = 16'h0000;
  logic        model_rs    = 1'b1;
  int          last_done   = -100;
  int          n_exp_done  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_rst"},  bus.TFT_RST,  1'b1);
    check({tag, "_cs_n"}, bus.TFT_CS_N, 1'b1);
    check({tag, "_wr_n"}, bus.TFT_WR_N, 1'b1);
    check({tag, "_rd_n"}, bus.TFT_RD_N, 1'b1);
    check({tag, "_db"},   bus.TFT_DB,   model_db);
    check({tag, "_rs"},   bus.TFT_RS,   model_rs);
  endtask

  // Issue one call, hold it until oDone, drop it, then compare the logged events.
  task automatic issue(input logic [2:0] call, input logic [15:0] data, input bit wiggle);
    int  n_cs0, n_wr0, n_rst0, n_done0, acc, kind, exp_done;
    bit  seen;
    n_cs0 = cs_fall_q.size(); n_wr0 = wr_fall_q.size();
    n_rst0 = rst_fall_q.size(); n_done0 = done_q.size();
    @(negedge CLOCK);
    acc = (cyc + 1 > last_done + 3) ? cyc + 1 : last_done + 3;
    kind = call[0] ? 0 : (call[1] ? 1 : 2);
    exp_done = (kind == 0) ? acc + T_RST_LOW + T_RST_WAIT : acc + T_SETUP + T_WRL + T_WRH;
    bus.iCall = call;
    bus.iData = data;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge CLOCK);
      if (bus.oDone === 1'b1) seen = 1;
      else if (wiggle && cyc >= acc) bus.iData = 16'($urandom);
    end
    bus.iCall = 3'b000;
    check("done_seen", seen, 1'b1);
    if (seen) begin
      n_exp_done++;
      last_done = cyc;
      check("done_cycle", cyc, exp_done);
      check("done_logged", done_q.size(), n_done0 + 1);
      if (kind == 0) begin
        check("rst_no_cs", cs_fall_q.size(), n_cs0);
        check("rst_no_wr", wr_fall_q.size(), n_wr0);
        check("rst_pulses", rst_fall_q.size(), n_rst0 + 1);
        if (rst_fall_q.size() == n_rst0 + 1) begin
          check("rst_start", rst_fall_q[n_rst0], acc);
          check("rst_width", rst_w_q[n_rst0], T_RST_LOW);
        end
      end else begin
        model_db = data;
        model_rs = (kind == 2);
        check("wr_no_rst", rst_fall_q.size(), n_rst0);
        check("cs_pulses", cs_fall_q.size(), n_cs0 + 1);
        check("wr_pulses", wr_fall_q.size(), n_wr0 + 1);
        if (cs_fall_q.size() == n_cs0 + 1) begin
          check("cs_start", cs_fall_q[n_cs0], acc);
          check("cs_width", cs_w_q[n_cs0], T_SETUP + T_WRL + T_WRH);
        end
        if (wr_fall_q.size() == n_wr0 + 1) begin
          check("wr_start", wr_fall_q[n_wr0], acc + T_SETUP);
          check("wr_width", wr_w_q[n_wr0], T_WRL);
          check("wr_db_fall", wr_dbf_q[n_wr0], data);
          check("wr_db_rise", wr_dbr_q[n_wr0], data);
          check("wr_rs", wr_rs_q[n_wr0], model_rs);
        end
      end
    end
    check_idle_pins("after_call");
  endtask

  // Start a request, then hit RESET a given number of cycles after acceptance.
  task automatic abort_at(input logic [2:0] call, input int offset);
    int acc, n_done0;
    n_done0 = done_q.size();
    @(negedge CLOCK);
    acc = (cyc + 1 > last_done + 3) ? cyc + 1 : last_done + 3;
    bus.iCall = call;
    bus.iData = 16'($urandom);
    for (int k = 0; k < 50 && cyc < acc + offset; k++) @(negedge CLOCK);
    if (call[0]) check("abort_pre_rst_low", bus.TFT_RST, 1'b0);
    else         check("abort_pre_wr_low", bus.TFT_WR_N, 1'b0);
    RESET = 1'b0;
    #1;
    model_db = 16'h0000;
    model_rs = 1'b1;
    check("abort_done", bus.oDone, 1'b0);
    check_idle_pins("abort");
    repeat (3) @(negedge CLOCK);
    bus.iCall = 3'b000;
    check("abort_no_done", done_q.size(), n_done0);
    RESET = 1'b1;
    last_done = -100;
  endtask

  initial begin
    bus.iCall = 3'b000;
    bus.iData = 16'h0000;
    #25;
    check("rst_done", bus.oDone, 1'b0);
    check_idle_pins("in_reset");
    @(negedge CLOCK);
    RESET = 1'b1;

    repeat (20) @(negedge CLOCK);
    check("idle_no_done", done_q.size(), 0);
    check("idle_done", bus.oDone, 1'b0);
    check_idle_pins("idle");

    issue(3'b001, 16'hABCD, 1'b0);
    issue(3'b010, 16'h002C, 1'b0);
    issue(3'b100, 16'hF800, 1'b0);
    issue(3'b100, 16'h07E0, 1'b0);
    issue(3'b100, 16'h001F, 1'b0);
    issue(3'b111, 16'h5A5A, 1'b1);
    issue(3'b010, 16'h1357, 1'b1);

    for (int i = 0; i < 10; i++)
      issue(3'($urandom_range(1, 7)), 16'($urandom), 1'($urandom));

    abort_at(3'b010, T_SETUP);
    issue(3'b010, 16'h002C, 1'b0);
    abort_at(3'b001, 1);
    issue(3'b100, 16'hBEEF, 1'b1);

    repeat (4) @(negedge CLOCK);
    check("total_done", done_q.size(), n_exp_done);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
